// File: rtl/mul_arb_pkg.sv
// Shared types and default configuration for the multiplier arbiter.
package mul_arb_pkg;

  localparam int unsigned NreqDefault    = 4;
  localparam int unsigned WDefault       = 32;
  localparam int unsigned TimeoutDefault = 40;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request selector: first set req bit searching upward from ptr,
// wrapping modulo NREQ. Purely combinational.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IdxW-1:0] index
);

  logic            found;
  logic [IdxW-1:0] cand;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IdxW'((32'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates NREQ requesters onto one shared multiplier, one operation in flight.
// Optional WAIT watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NREQ    = NreqDefault,
  parameter int unsigned W       = WDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_sign,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*W-1:0]    rsp_product,
  output logic              rsp_err,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_sign,
  input  logic [2*W-1:0]    mul_product,
  input  logic              mul_done
);

  localparam int unsigned IdxW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gidx_q, gidx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sign_q, sign_d;
  logic [2*W-1:0]  prod_q, prod_d;

  logic [NREQ-1:0] arb_grant;
  logic [IdxW-1:0] arb_idx;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .index (arb_idx)
  );

  // Next-state: grant in IDLE, pulse start, wait for done (or watchdog), respond.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    prod_d  = prod_q;
`ifdef MUL_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (|req_valid) begin
          state_d = StIssue;
          gidx_d  = arb_idx;
          ptr_d   = (32'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
          a_d     = req_a[arb_idx*W +: W];
          b_d     = req_b[arb_idx*W +: W];
          sign_d  = req_sign[arb_idx];
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        if (mul_done) begin
          state_d = StResp;
          prod_d  = mul_product;
`ifdef MUL_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StResp;
          prod_d  = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gidx_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      prod_q  <= prod_d;
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  // Watchdog counter and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Ready is gated by rst so a held request cannot leak through during reset.
  assign req_ready   = (state_q == StIdle && !rst) ? arb_grant : '0;
  assign mul_start   = (state_q == StIssue);
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign mul_sign    = sign_q;
  assign rsp_product = prod_q;

  // One-hot response strobe for the stored grant index.
  always_comb begin
    rsp_valid = '0;
    if (state_q == StResp) rsp_valid[gidx_q] = 1'b1;
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a scoreboard of expected grants and responses.
module tb_mul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  typedef struct {
    int          idx;
    logic [63:0] prod;
    logic        err;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sign;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*W-1:0]    rsp_product;
  logic              rsp_err;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_sign;
  logic [2*W-1:0]    mul_product;
  logic              mul_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_grants = 0, n_rsp = 0;
  int last_grant_cyc = 0, last_rsp_cyc = 0, last_gap = 0;
  int ready_multi = 0;

  int   mul_lat = 1;
  logic mul_hang = 1'b0;
  logic stray_issue = 1'b0;
  int   stray_req = 0, stray_served = 0;

  int   exp_grant[$];
  rsp_t exp_rsp[$];

  mul_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sign    (req_sign),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_sign    (mul_sign),
    .mul_product (mul_product),
    .mul_done    (mul_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // External multiplier model: fixed latency after the start pulse, optional stray dones.
  initial begin
    logic [63:0] res;
    int          left;
    logic        busy;
    busy = 1'b0;
    left = 0;
    res  = '0;
    mul_done    = 1'b0;
    mul_product = '0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (busy) begin
        left--;
        if (left == 0) begin
          mul_done    = 1'b1;
          mul_product = res;
          busy        = 1'b0;
        end
      end
      if (mul_start) begin
        res  = ref_mul(mul_a, mul_b, mul_sign);
        left = mul_lat;
        busy = !mul_hang;
        if (stray_issue) begin
          mul_done    = 1'b1;
          mul_product = 64'hDEAD_BEEF_0BAD_F00D;
        end
      end else if (stray_req != stray_served && !busy) begin
        mul_done    = 1'b1;
        mul_product = 64'h0BAD_0BAD_0BAD_0BAD;
        stray_served++;
      end
    end
  end

  // Monitor: match every grant and response against the scoreboard.
  initial begin
    int   g;
    rsp_t e;
    forever begin
      @(negedge clk);
      if ($countones(req_ready) > 1) ready_multi++;
      if (req_ready != '0) begin
        if (n_grants > 0) last_gap = cyc - last_grant_cyc;
        n_grants++;
        last_grant_cyc = cyc;
        if (exp_grant.size() == 0) check_eq("grant_unexpected", 64'(req_ready), 64'd0);
        else begin
          g = exp_grant.pop_front();
          check_eq("grant", 64'(req_ready), 64'd1 << g);
        end
      end
      if (rsp_valid != '0) begin
        n_rsp++;
        last_rsp_cyc = cyc;
        if (exp_rsp.size() == 0) check_eq("rsp_unexpected", 64'(rsp_valid), 64'd0);
        else begin
          e = exp_rsp.pop_front();
          check_eq("rsp_valid", 64'(rsp_valid), 64'd1 << e.idx);
          check_eq("rsp_product", rsp_product, e.prod);
          check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
    end
  end

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_sign[idx]     = s;
  endtask

  task automatic wait_grants(input int target, input int budget, input string tag);
    int k = 0;
    while (n_grants < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq(tag, 64'(n_grants >= target), 64'd1);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k = 0;
    while ((exp_rsp.size() != 0 || exp_grant.size() != 0) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq(tag, 64'(exp_rsp.size() + exp_grant.size()), 64'd0);
  endtask

  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int lat, input logic [63:0] prod,
                        input logic err, input string tag);
    set_op(idx, a, b, s);
    mul_lat = lat;
    exp_grant.push_back(idx);
    exp_rsp.push_back('{idx: idx, prod: prod, err: err});
    req_valid[idx] = 1'b1;
    wait_grants(n_grants + 1, 10, {tag, "_grant"});
    req_valid = '0;
    wait_drain(lat + 60, {tag, "_drain"});
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_rsp_product"}, rsp_product, 64'd0);
    check_eq({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check_eq({tag, "_mul_start"}, 64'(mul_start), 64'd0);
    check_eq({tag, "_mul_a"}, 64'(mul_a), 64'd0);
    check_eq({tag, "_mul_b"}, 64'(mul_b), 64'd0);
    check_eq({tag, "_mul_sign"}, 64'(mul_sign), 64'd0);
  endtask

  initial begin
    int          nr;
    logic [31:0] op_a[4];
    logic [31:0] op_b[4];
    logic        op_s[4];
    int          order[5];

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sign  = '0;
    op_a = '{32'd123, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    op_b = '{32'hFFFF_FFD3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
    op_s = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < NREQ; i++) set_op(i, op_a[i], op_b[i], op_s[i]);

    // All four request from reset onward; outputs must stay quiet during reset.
    req_valid = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");

    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      exp_grant.push_back(order[i]);
      exp_rsp.push_back('{idx: order[i],
                          prod: ref_mul(op_a[order[i]], op_b[order[i]], op_s[order[i]]),
                          err: 1'b0});
    end
    mul_lat = 1;
    rst = 1'b0;
    wait_grants(5, 80, "rr_grants");
    req_valid = '0;
    wait_drain(40, "rr_drain");
    check_eq("rr_no_bubble_gap", 64'(last_gap), 64'd4);
    check_eq("min_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'd3);

    // Signed single request, done 17 cycles after start.
    run_op(0, 32'd7, 32'hFFFF_FFFD, 1'b1, 17, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "signed");
    check_eq("signed_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'd19);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rsp_product_hold", rsp_product, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(2, 32'hFFFF_FFFF, 32'd2, 1'b0, 5, 64'h1_FFFF_FFFE, 1'b0, "unsigned");

    // Stray done in IDLE, then another during ISSUE of a real op.
    nr = n_rsp;
    stray_req++;
    repeat (5) @(posedge clk);
    #1;
    check_eq("stray_idle_served", 64'(stray_served), 64'(stray_req));
    check_eq("stray_idle_no_rsp", 64'(n_rsp), 64'(nr));
    stray_issue = 1'b1;
    run_op(3, 32'd100, 32'd200, 1'b0, 4, 64'd20000, 1'b0, "stray_issue");
    stray_issue = 1'b0;
    check_eq("stray_issue_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'd6);
    check_eq("stray_rsp_count", 64'(n_rsp), 64'(nr + 1));

    // Reset during WAIT: no response, late done ignored, pointer back to 0.
    mul_lat = 12;
    exp_grant.push_back(1);
    req_valid = 4'b0010;
    wait_grants(n_grants + 1, 10, "rstwait_grant");
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rstwait_mul_a_live", 64'(mul_a), 64'h8000_0000);
    rst = 1'b1;
    #2;
    check_outputs_zero("rstwait");
    @(posedge clk);
    #1;
    rst = 1'b0;
    nr = n_rsp;
    repeat (15) @(posedge clk);
    #1;
    check_eq("rstwait_no_rsp", 64'(n_rsp), 64'(nr));
    mul_lat = 1;
    set_op(0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    exp_grant.push_back(0);
    exp_rsp.push_back('{idx: 0, prod: 64'hFFFF_FFFF_FFFF_FFEB, err: 1'b0});
    req_valid = 4'hF;
    wait_grants(n_grants + 1, 10, "post_rst_grant");
    req_valid = '0;
    wait_drain(40, "post_rst_drain");

`ifdef MUL_ARB_TIMEOUT_EN
    mul_hang = 1'b1;
    run_op(3, 32'd9, 32'd9, 1'b0, 1, 64'd0, 1'b1, "timeout");
    mul_hang = 1'b0;
    check_eq("timeout_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'd42);
`else
    run_op(3, 32'd9, 32'd9, 1'b0, 60, 64'd81, 1'b0, "long_wait");
    check_eq("long_wait_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'd62);
`endif

    check_eq("ready_onehot_violations", 64'(ready_multi), 64'd0);
    check_eq("queues_empty", 64'(exp_grant.size() + exp_rsp.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter W, default 32: operand width. The product width is 2W.
REQ-003 Parameter TIMEOUT, default 40: WAIT-state cycle limit. Used only when MUL_ARB_TIMEOUT_EN is defined.
REQ-004 Port clk, input, 1 bit: clock. All state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port req_valid, input, NREQ bits: per-requester operation request.
REQ-007 Port req_ready, output, NREQ bits: per-requester accept strobe.
REQ-008 Ports req_a and req_b, input, NREQ*W bits each: packed operands. Requester i occupies bits [i*W +: W].
REQ-009 Port req_sign, input, NREQ bits: per-requester signed-multiply select.
REQ-010 Port rsp_valid, output, NREQ bits: one-hot, single-cycle response strobe.
REQ-011 Port rsp_product, output, 2W bits: shared response data bus.
REQ-012 Port rsp_err, output, 1 bit: timeout flag, qualified by rsp_valid.
REQ-013 Port mul_start, output, 1 bit: single-cycle start pulse to the shared multiplier.
REQ-014 Ports mul_a and mul_b, output, W bits each; port mul_sign, output, 1 bit: multiplier operands and sign select.
REQ-015 Port mul_product, input, 2W bits; port mul_done, input, 1 bit: multiplier result and completion strobe.

Function
REQ-016 The block SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP, and SHALL have exactly one operation in flight at a time.
REQ-017 In IDLE with req_valid nonzero, the block SHALL grant index g and assert req_ready[g] combinationally in the same cycle. g is the first set req_valid bit searching upward from ptr, wrapping modulo NREQ.
REQ-018 On the grant edge, the block SHALL capture req_a[g], req_b[g] and req_sign[g] into registers, store g, set ptr = (g+1) mod NREQ, and go to ISSUE.
REQ-019 req_ready SHALL be all-zero in every state except IDLE, and SHALL never have more than one bit set.
REQ-020 In ISSUE, the block SHALL assert mul_start for exactly one cycle, then go to WAIT.
REQ-021 mul_a, mul_b and mul_sign SHALL hold the captured operands stable from ISSUE through the end of WAIT.
REQ-022 In WAIT, on mul_done=1 the block SHALL register mul_product and go to RESP. mul_done SHALL be ignored in all other states.
REQ-023 In RESP, the block SHALL assert rsp_valid[g] for one cycle with rsp_product valid, then return to IDLE. Responses have no backpressure.
REQ-024 rsp_product SHALL hold its last value outside RESP.
REQ-025 Latency: grant at cycle 0, mul_start at cycle 1, response at the cycle after mul_done. Minimum latency is 3 cycles.
REQ-026 A requester that deasserts req_valid while not granted SHALL lose no state. Requests are level-sensitive.
REQ-027 When a new request is present in IDLE directly after RESP, it SHALL be granted with no idle bubble.

Reset
REQ-028 While rst is asserted, the block SHALL be in state IDLE with ptr=0 and grant register 0.
REQ-029 While rst is asserted, all outputs SHALL be 0: req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b, mul_sign.
REQ-030 On reset mid-operation, the in-flight operation SHALL be discarded with no response. A late mul_done after reset SHALL be ignored.

Configuration
REQ-031 With MUL_ARB_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT and increment each cycle spent in WAIT.
REQ-032 With MUL_ARB_TIMEOUT_EN defined, reaching TIMEOUT without mul_done SHALL force RESP with rsp_err=1 and rsp_product=0. rsp_err SHALL be 0 on normal completion.
REQ-033 Without MUL_ARB_TIMEOUT_EN, no timeout counter SHALL exist, rsp_err SHALL be tied to 0, and WAIT SHALL last until mul_done.

Structure
REQ-034 Package mul_arb_pkg SHALL contain the state enum type and the default values for NREQ, W and TIMEOUT.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter with inputs req and ptr and outputs a one-hot grant and an index.

Verification
REQ-036 Single request: NREQ=4; req_valid=0001, a=7, b=-3, sign=1; mul_done 17 cycles after start -> rsp_valid=0001, rsp_product=-21 (64-bit), rsp_err=0.
REQ-037 Round robin: req_valid=1111 held continuously from reset -> grants in order 0,1,2,3,0, with no requester granted twice before all four are granted.
REQ-038 Stray done: mul_done pulsed in IDLE and in ISSUE -> no rsp_valid is produced, and the FSM state is unchanged apart from the normal ISSUE-to-WAIT advance.
REQ-039 Reset mid-WAIT: rst asserted during WAIT, then mul_done arrives -> no response; the next grant goes to index 0.
REQ-040 Timeout, with MUL_ARB_TIMEOUT_EN and TIMEOUT=40: mul_done never asserted -> 40 cycles after entering WAIT, rsp_valid[g]=1, rsp_err=1, rsp_product=0.
REQ-041 Unsigned operation: sign=0, a=0xFFFFFFFF, b=2 -> rsp_product=0x1FFFFFFFE.
